emergency_request_conditioner: RTL and testbench

- Upstream front end for the intersection controller's Emergency_left / Emergency_right inputs.
- Takes raw, asynchronous siren-detector levels and synchronises and debounces them.
- Latches each detection as a pending request and arbitrates left against right.
- Issues one clean, fixed-length emergency pulse per detection, followed by a cooldown, so the controller never sees glitches, overlapping requests or back-to-back retriggers.

---
 rtl/emergency_request_conditioner.sv | 177 +++++++++++++++++
 tb/tb_emergency_request_conditioner.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/emergency_request_conditioner.sv
// emergency_request_conditioner
//
// Front end for the intersection controller's emergency inputs. It
// synchronises and debounces the two raw siren-detector levels. Each new
// detection is latched as a pending request, and left is arbitrated against
// right. Each grant becomes one fixed-length pulse followed by a cooldown.
//
// States:
//   IDLE     | waiting for a pending request while enabled
//   ASSERT   | one Emergency output high, timer counts HOLD_CYCLES down
//   COOLDOWN | both outputs low, timer counts COOLDOWN_CYCLES down
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   siren_left_raw   raw left detector level (asynchronous)
//   siren_right_raw  raw right detector level (asynchronous)
//   enable           0 blocks grants, aborts a pulse, clears pendings
//   Emergency_left   registered left pulse, HOLD_CYCLES long
//   Emergency_right  registered right pulse, HOLD_CYCLES long
//   busy             high in ASSERT or COOLDOWN
//   req_count        grants since reset, saturating at 255
module emergency_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 10,
    parameter int COOLDOWN_CYCLES = 20,
    parameter int CNT_W           = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       siren_left_raw,
    input  logic       siren_right_raw,
    input  logic       enable,
    output logic       Emergency_left,
    output logic       Emergency_right,
    output logic       busy,
    output logic [7:0] req_count
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    // Bit 0 is the left side, bit 1 the right side throughout.
    logic [1:0]            sync1_q;
    logic [1:0]            s_q;
    logic [1:0]            db_q, db_d;
    logic [1:0][CNT_W-1:0] dcnt_q, dcnt_d;
    logic [1:0]            pend_q, pend_d;
    logic [1:0]            em_q, em_d;
    logic [1:0]            rise;
    logic [1:0]            grant;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      timer_q, timer_d;
    logic                  last_left_q, last_left_d;
    logic                  busy_q, busy_d;
    logic [7:0]            req_count_q, req_count_d;

    // Debounce: the level changes only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; rise flags the 0->1 change of the debounced level.
    always_comb begin
        db_d   = db_q;
        dcnt_d = dcnt_q;
        rise   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (s_q[i] == db_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DEB_LAST) begin
                db_d[i]   = s_q[i];
                dcnt_d[i] = '0;
                rise[i]   = s_q[i];
            end else begin
                dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        em_d        = em_q;
        pend_d      = pend_q;
        last_left_d = last_left_q;
        req_count_d = req_count_q;
        grant       = 2'b00;
        if (!enable) begin
            state_d = IDLE;
            timer_d = '0;
            em_d    = 2'b00;
            pend_d  = 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|pend_q) begin
                        // Ties alternate; a lone request does not move the tie pointer.
                        if (&pend_q) begin
                            grant       = last_left_q ? 2'b10 : 2'b01;
                            last_left_d = ~last_left_q;
                        end else begin
                            grant = pend_q;
                        end
                        state_d = ASSERT;
                        timer_d = HOLD_LAST;
                        em_d    = grant;
                        if (req_count_q != 8'hFF) begin
                            req_count_d = req_count_q + 8'd1;
                        end
                    end
                end
                ASSERT: begin
                    if (timer_q == '0) begin
                        em_d    = 2'b00;
                        state_d = COOLDOWN;
                        timer_d = COOL_LAST;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (timer_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                    em_d    = 2'b00;
                end
            endcase
            // A new edge on the side being granted re-arms its pending.
            pend_d = (pend_q & ~grant) | rise;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 2'b00;
            s_q         <= 2'b00;
            db_q        <= 2'b00;
            dcnt_q      <= '0;
            pend_q      <= 2'b00;
            em_q        <= 2'b00;
            state_q     <= IDLE;
            timer_q     <= '0;
            last_left_q <= 1'b0;
            busy_q      <= 1'b0;
            req_count_q <= 8'd0;
        end else begin
            sync1_q     <= {siren_right_raw, siren_left_raw};
            s_q         <= sync1_q;
            db_q        <= db_d;
            dcnt_q      <= dcnt_d;
            pend_q      <= pend_d;
            em_q        <= em_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            last_left_q <= last_left_d;
            busy_q      <= busy_d;
            req_count_q <= req_count_d;
        end
    end

    assign Emergency_left  = em_q[0];
    assign Emergency_right = em_q[1];
    assign busy            = busy_q;
    assign req_count       = req_count_q;

endmodule

// File: tb/tb_emergency_request_conditioner.sv
module tb_emergency_request_conditioner;

    localparam int DEB = 4;
    localparam int H   = 10;
    localparam int C   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       raw_l = 1'b0;
    logic       raw_r = 1'b0;
    logic       en = 1'b1;
    logic       em_l, em_r, busy;
    logic [7:0] req_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    emergency_request_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES(H),
        .COOLDOWN_CYCLES(C),
        .CNT_W(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .siren_left_raw(raw_l),
        .siren_right_raw(raw_r),
        .enable(en),
        .Emergency_left(em_l),
        .Emergency_right(em_r),
        .busy(busy),
        .req_count(req_count)
    );

    // Reference model: time-stamped grants instead of a state machine.
    int m_s1[2], m_s[2], m_db[2], m_run[2], m_pend[2];
    int m_side, m_g, m_last_left, m_count, n;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s[i] = 0; m_db[i] = 0; m_run[i] = 0; m_pend[i] = 0;
        end
        m_side = -1; m_g = 0; m_last_left = 0; m_count = 0; n = 0;
    endtask

    task automatic model_edge(input bit rl, input bit rr, input bit e);
        int raw[2];
        int rise[2];
        int g;
        raw[0] = rl; raw[1] = rr;
        n++;
        for (int i = 0; i < 2; i++) begin
            rise[i] = 0;
            if (m_s[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_db[i] = m_s[i]; m_run[i] = 0; rise[i] = m_db[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (!e) begin
            m_side = -1; m_pend[0] = 0; m_pend[1] = 0;
        end else begin
            if ((m_side < 0 || n >= m_g + H + C + 1) && (m_pend[0] == 1 || m_pend[1] == 1)) begin
                if (m_pend[0] == 1 && m_pend[1] == 1) begin
                    g = (m_last_left == 1) ? 1 : 0;
                    m_last_left = (g == 0) ? 1 : 0;
                end else begin
                    g = (m_pend[0] == 1) ? 0 : 1;
                end
                m_pend[g] = 0; m_side = g; m_g = n;
                if (m_count < 255) m_count++;
            end
            for (int i = 0; i < 2; i++) if (rise[i] == 1) m_pend[i] = 1;
        end
        for (int i = 0; i < 2; i++) begin
            m_s[i] = m_s1[i]; m_s1[i] = raw[i];
        end
    endtask

    function automatic int m_out(input int side);
        return (m_side == side && n < m_g + H) ? 1 : 0;
    endfunction

    function automatic int m_busy();
        return (m_side >= 0 && n < m_g + H + C) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s edge=%0d t=%0t got=%0d expected=%0d", name, n, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(raw_l, raw_r, en);
        #1;
        check("model_left", int'(em_l), m_out(0));
        check("model_right", int'(em_r), m_out(1));
        check("model_busy", int'(busy), m_busy());
        check("model_count", int'(req_count), m_count);
    endtask

    task automatic do_reset();
        rst = 1'b1; raw_l = 1'b0; raw_r = 1'b0; en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("reset_left", int'(em_l), 0);
        check("reset_right", int'(em_r), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_count", int'(req_count), 0);
    endtask

    typedef struct {
        int id;
        int edge_n;
        bit drv;
        bit rl, rr, e;
        bit chk;
        bit xl, xr, xb;
        int xc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_drv(input int id, input int ed, input bit rl, input bit rr, input bit e);
        vec_t v;
        v = '{id, ed, 1'b1, rl, rr, e, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs.push_back(v);
    endfunction

    function automatic void add_chk(input int id, input int ed, input bit xl, input bit xr, input bit xb, input int xc);
        vec_t v;
        v = '{id, ed, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, xl, xr, xb, xc};
        vecs.push_back(v);
    endfunction

    task automatic apply_edge(input int id, input int ed);
        foreach (vecs[k]) begin
            if (vecs[k].id == id && vecs[k].edge_n == ed) begin
                if (vecs[k].drv) begin
                    raw_l = vecs[k].rl; raw_r = vecs[k].rr; en = vecs[k].e;
                end
                if (vecs[k].chk) begin
                    check($sformatf("vec%0d_e%0d_left", id, ed), int'(em_l), int'(vecs[k].xl));
                    check($sformatf("vec%0d_e%0d_right", id, ed), int'(em_r), int'(vecs[k].xr));
                    check($sformatf("vec%0d_e%0d_busy", id, ed), int'(busy), int'(vecs[k].xb));
                    check($sformatf("vec%0d_e%0d_count", id, ed), int'(req_count), vecs[k].xc);
                end
            end
        end
    endtask

    task automatic run_table(input int id, input int last_edge);
        apply_edge(id, 0);
        for (int e = 1; e <= last_edge; e++) begin
            tick();
            apply_edge(id, e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        // 1: single left detection, default latency and widths
        add_drv(1, 0, 1, 0, 1);
        add_chk(1, 6, 0, 0, 0, 0);
        add_chk(1, 7, 1, 0, 1, 1);
        add_chk(1, 16, 1, 0, 1, 1);
        add_chk(1, 17, 0, 0, 1, 1);
        add_chk(1, 36, 0, 0, 1, 1);
        add_chk(1, 37, 0, 0, 0, 1);
        // 3: simultaneous rise, then a repeat tie
        add_drv(3, 0, 1, 1, 1);
        add_chk(3, 7, 1, 0, 1, 1);
        add_chk(3, 16, 1, 0, 1, 1);
        add_chk(3, 17, 0, 0, 1, 1);
        add_chk(3, 37, 0, 0, 0, 1);
        add_chk(3, 38, 0, 1, 1, 2);
        add_chk(3, 47, 0, 1, 1, 2);
        add_chk(3, 48, 0, 0, 1, 2);
        add_drv(3, 40, 0, 0, 1);
        add_drv(3, 52, 1, 1, 1);
        add_chk(3, 68, 0, 0, 0, 2);
        add_chk(3, 69, 0, 1, 1, 3);
        add_chk(3, 99, 0, 0, 0, 3);
        add_chk(3, 100, 1, 0, 1, 4);
        // 4: left re-detected during cooldown
        add_drv(4, 0, 1, 0, 1);
        add_drv(4, 10, 0, 0, 1);
        add_drv(4, 16, 1, 0, 1);
        add_chk(4, 7, 1, 0, 1, 1);
        add_chk(4, 37, 0, 0, 0, 1);
        add_chk(4, 38, 1, 0, 1, 2);
        // 5: enable dropped mid-pulse
        add_drv(5, 0, 1, 0, 1);
        add_drv(5, 2, 1, 1, 1);
        add_chk(5, 10, 1, 0, 1, 1);
        add_drv(5, 10, 1, 1, 0);
        add_chk(5, 11, 0, 0, 0, 1);
        add_drv(5, 15, 1, 1, 1);
        add_chk(5, 60, 0, 0, 0, 1);
        add_drv(5, 60, 0, 1, 1);
        add_drv(5, 70, 1, 1, 1);
        add_chk(5, 76, 0, 0, 0, 1);
        add_chk(5, 77, 1, 0, 1, 2);
        add_chk(5, 80, 1, 0, 1, 2);

        model_reset();
        do_reset();
        run_table(1, 45);

        do_reset();
        seen = 0;
        for (int p = 0; p < 8; p++) begin
            raw_r = 1'b1;
            repeat (3) begin tick(); if (em_r) seen = 1; end
            raw_r = 1'b0;
            repeat (2) begin tick(); if (em_r) seen = 1; end
        end
        repeat (10) begin tick(); if (em_r) seen = 1; end
        check("glitch_no_right_pulse", seen, 0);
        check("glitch_count", int'(req_count), 0);

        do_reset();
        run_table(3, 110);

        do_reset();
        run_table(4, 60);

        do_reset();
        run_table(5, 80);
        rst = 1'b1;
        #1;
        check("async_rst_left", int'(em_l), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_count", int'(req_count), 0);

        do_reset();
        for (int p = 0; p < 300; p++) begin
            raw_l = 1'b1;
            repeat (20) tick();
            raw_l = 1'b0;
            repeat (20) tick();
        end
        check("saturated_count", int'(req_count), 255);

        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) raw_l = ~raw_l;
            if ($urandom_range(0, 7) == 0) raw_r = ~raw_r;
            if (en && $urandom_range(0, 59) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
